// File: rtl/fila_instrucoes_if.sv
// Issue-side bus between the instruction queue and the reservation station.
interface fila_instrucoes_if;
  logic [15:0] instrucao_out;
  logic        nv_inst;
  logic [2:0]  endr_Vj;
  logic [2:0]  endr_Vk;
  logic        SR_R_cheia;
  logic        SR_I_cheia;

  modport master (
    output instrucao_out, nv_inst, endr_Vj, endr_Vk,
    input  SR_R_cheia, SR_I_cheia
  );

  modport slave (
    input  instrucao_out, nv_inst, endr_Vj, endr_Vk,
    output SR_R_cheia, SR_I_cheia
  );
endinterface

// File: rtl/fila_instrucoes.sv
// In-order instruction FIFO with an issue stage that waits out a settle window
// after every issue so the registered reservation-station full flags catch up.
module fila_instrucoes #(
  parameter int DEPTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic                       wr_en,
  input  logic [15:0]                instr_wr,
  input  logic                       flush,
  fila_instrucoes_if.master          issue,
  output logic                       fila_cheia,
  output logic                       fila_vazia,
  output logic [$clog2(DEPTH+1)-1:0] ocupacao,
  output logic                       overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE, SETTLE} estado_t;

  // R-class reads [10:8]/[7:5]; I-class reads store data/dest [13:11] and base [10:8]
  function automatic logic [5:0] decode_endr(input logic [15:0] w);
    if (w[15]) begin
      decode_endr = {w[13:11], w[10:8]};
    end else begin
      decode_endr = {w[10:8], w[7:5]};
    end
  endfunction

  logic [15:0]   mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r;
  logic [CW-1:0] count_r, count_nxt_s;
  logic [1:0]    settle_cnt_r;
  estado_t       state_r, next_state_s;
  logic          fila_cheia_r, fila_vazia_r, overflow_r;
  logic [15:0]   instrucao_r;
  logic [2:0]    endr_vj_r, endr_vk_r;
  logic          nv_inst_r;
  logic [15:0]   head_s;
  logic          head_full_s, issue_s, push_s, drop_s;
  logic [5:0]    endr_s;

  // Next-state and issue decision
  always_comb begin
    next_state_s = state_r;
    issue_s      = 1'b0;
    head_s       = mem_r[rd_ptr_r];
    head_full_s  = head_s[15] ? issue.SR_I_cheia : issue.SR_R_cheia;
    endr_s       = decode_endr(head_s);
    case (state_r)
      IDLE: begin
        if (!fila_vazia_r && !head_full_s && !flush) begin
          issue_s      = 1'b1;
          next_state_s = SETTLE;
        end else begin
          next_state_s = IDLE;
        end
      end
      SETTLE: begin
        if (flush || (settle_cnt_r == 2'(SETTLE_CYCLES - 1))) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = SETTLE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Push acceptance and next occupancy; a push that coincides with an issue fits even when full
  always_comb begin
    push_s      = wr_en && !flush && (!fila_cheia_r || issue_s);
    drop_s      = wr_en && !flush && fila_cheia_r && !issue_s;
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({push_s, issue_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // FSM state and settle counter
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r      <= IDLE;
      settle_cnt_r <= 2'd0;
    end else begin
      state_r <= next_state_s;
      if ((state_r == SETTLE) && (next_state_s == SETTLE)) begin
        settle_cnt_r <= settle_cnt_r + 2'd1;
      end else begin
        settle_cnt_r <= 2'd0;
      end
    end
  end

  // Storage array, no reset needed since pointers define validity
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= instr_wr;
    end
  end

  // Pointers, flags and registered issue outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      fila_vazia_r <= 1'b1;
      fila_cheia_r <= 1'b0;
      overflow_r   <= 1'b0;
      nv_inst_r    <= 1'b0;
      instrucao_r  <= 16'h0000;
      endr_vj_r    <= 3'd0;
      endr_vk_r    <= 3'd0;
    end else begin
      nv_inst_r <= issue_s;
      if (issue_s) begin
        instrucao_r <= head_s;
        endr_vj_r   <= endr_s[5:3];
        endr_vk_r   <= endr_s[2:0];
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      if (flush) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PW'(1);
        end
        if (issue_s) begin
          rd_ptr_r <= rd_ptr_r + PW'(1);
        end
      end
      count_r      <= count_nxt_s;
      fila_vazia_r <= (count_nxt_s == {CW{1'b0}});
      fila_cheia_r <= (count_nxt_s == CW'(DEPTH));
    end
  end

  assign issue.instrucao_out = instrucao_r;
  assign issue.nv_inst       = nv_inst_r;
  assign issue.endr_Vj       = endr_vj_r;
  assign issue.endr_Vk       = endr_vk_r;
  assign fila_cheia          = fila_cheia_r;
  assign fila_vazia          = fila_vazia_r;
  assign ocupacao            = count_r;
  assign overflow            = overflow_r;

endmodule
